csa_seq_add_ctrl: RTL and testbench
===================================

Name: csa_seq_add_ctrl

Overview:
- Sequencing controller that adds two WIDTH-bit operands using a single 4-bit carry-select adder slice, one nibble per clock, LSB nibble first.
- The carry is chained through a register between slices.
- A start/busy/done handshake frames each operation.
- The block sits between a requester (ALU/accumulator front end) and the shared 4-bit carry-select slice, which is instantiated inside this block.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NSLICE, WIDTH/4, derived local parameter; number of nibble slices per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when the block is idle or done
- a  input  WIDTH  operand A; captured on the accepting edge
- b  input  WIDTH  operand B; captured on the accepting edge
- cin  input  1  initial carry-in; captured on the accepting edge
- busy  output  1  high while slices are being processed
- done  output  1  one-cycle pulse; sum/cout/overflow valid
- sum  output  WIDTH  registered result
- cout  output  1  carry out of the MSB nibble
- overflow  output  1  signed overflow: carry into bit WIDTH-1 XOR cout

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - state=IDLE.
  - busy=0, done=0, sum=0, cout=0, overflow=0.
  - Slice index=0, carry register=0, operand registers=0.
- States: IDLE, RUN, DONE. One-hot or binary encoding is acceptable.
- IDLE:
  - start=1 at an edge: latch a, b, cin; set carry register=cin; set idx=0; go to RUN.
  - start=0: remain in IDLE.
- RUN (busy=1):
  - At each edge, the slice adds a[4*idx+3:4*idx] + b[4*idx+3:4*idx] + carry.
  - The 4-bit result is written into sum[4*idx+3:4*idx]; the carry register takes the slice carry-out; idx increments.
  - When idx=NSLICE-1 at the edge:
    - cout takes the slice carry-out.
    - overflow takes (carry into bit WIDTH-1) XOR (slice carry-out).
    - idx wraps to 0; go to DONE.
- DONE (busy=0, done=1 for exactly one cycle):
  - sum, cout and overflow are final.
  - At the next edge: start=1 is accepted exactly as in IDLE (back-to-back, no bubble) and the state goes to RUN; otherwise go to IDLE.
- Latency:
  - done is high in the cycle following the NSLICE-th edge after the accepting edge.
  - Accept-to-accept throughput is NSLICE+1 cycles.
- Output holding:
  - sum/cout/overflow hold their values in IDLE until the next accepted start.
  - During RUN, sum is partially updated (upper nibbles stale) and is valid only when done=1.
- start during RUN: ignored. No queuing, and the operand registers are unchanged.
- Operand inputs a/b/cin may change freely after the accepting edge.
- Reset mid-RUN: the operation is aborted and all outputs return to reset values immediately; no done pulse is generated.
- All arithmetic is unsigned modulo 2^WIDTH, with the carry captured separately in cout.
- No combinational path from any input to any output. All outputs are registered.

Test Plan:
- WIDTH=16. Reset, then start with a=0x1234, b=0x4321, cin=0 → busy high for 4 cycles, then done=1 for one cycle with sum=0x5555, cout=0, overflow=0.
- a=0xFFFF, b=0x0000, cin=1 (carry ripples through all 4 slices) → sum=0x0000, cout=1, overflow=0.
- a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, overflow=1. Then a=0x8000, b=0x8000 → sum=0x0000, cout=1, overflow=1.
- Start 0x000A+0x0002. Pulse start again with a=0xFFFF in the second RUN cycle → result 0x000C. The second request is ignored, and exactly one done pulse occurs.
- Back-to-back: hold start=1 with new operands 0x00FF+0x0001 during the DONE cycle → next done pulse arrives 5 cycles later with sum=0x0100. No IDLE cycle between operations.
- Assert rst_n=0 asynchronously during the 2nd RUN cycle of 0x1111+0x1111 → busy, done and sum drop to 0 immediately, with no done pulse. After release, a fresh 0x0001+0x0001 yields sum=0x0002.

Source files
------------

// File: rtl/csa_seq_add_ctrl.sv
// Sequential WIDTH-bit adder: one 4-bit carry-select slice is reused per nibble, LSB first,
// with the inter-nibble carry held in a register and a start/busy/done handshake.

module csa_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       c3
);
    logic [2:0] w_lo;
    logic [2:0] w_hi0;
    logic [2:0] w_hi1;
    logic [2:0] w_hi;

    // Low pair ripples; the high pair is precomputed for both carries and selected.
    assign w_lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
    assign w_hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
    assign w_hi1 = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;
    assign w_hi  = w_lo[2] ? w_hi1 : w_hi0;

    assign s    = {w_hi[1:0], w_lo[1:0]};
    assign cout = w_hi[2];
    assign c3   = a[3] ^ b[3] ^ s[3];
endmodule

module csa_seq_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IW     = $clog2(NSLICE);
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [IW-1:0]    r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_busy;
    logic             r_done;
    logic             r_cout;
    logic             r_ovf;

    logic [3:0]       w_s;
    logic             w_co;
    logic             w_c3;

    csa_slice4 u_slice (
        .a    (r_a[{r_idx, 2'b00} +: 4]),
        .b    (r_b[{r_idx, 2'b00} +: 4]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_co),
        .c3   (w_c3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                // DONE accepts a new request exactly like IDLE, giving back-to-back operation.
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_sum[{r_idx, 2'b00} +: 4] <= w_s;
                    r_carry <= w_co;
                    if (r_idx == LAST) begin
                        r_cout  <= w_co;
                        r_ovf   <= w_c3 ^ w_co;
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;
endmodule

// File: tb/tb_csa_seq_add_ctrl.sv
// Bench for csa_seq_add_ctrl: cycle-level arithmetic model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.

module tb_csa_seq_add_ctrl;
    localparam int W      = 16;
    localparam int NSLICE = W / 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    csa_seq_add_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a request is taken whenever no operation is in flight; the result
    // appears NSLICE edges later as plain (W+1)-bit addition with signed-overflow rule.
    logic [W:0]   full;
    int           m_cnt;
    logic         m_done;
    logic [W-1:0] m_sum, p_sum;
    logic         m_cout, p_cout, m_ovf, p_ovf;

    assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
        end else begin
            m_done <= (m_cnt == 1);
            if (m_cnt == 1) begin
                m_sum  <= p_sum;
                m_cout <= p_cout;
                m_ovf  <= p_ovf;
            end
            if (m_cnt == 0 && start) begin
                m_cnt  <= NSLICE;
                p_sum  <= full[W-1:0];
                p_cout <= full[W];
                p_ovf  <= (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_cnt != 0));
        chk("done", 32'(done), 32'(m_done));
        if (m_cnt == 0) begin
            chk("sum", 32'(sum), 32'(m_sum));
            chk("cout", 32'(cout), 32'(m_cout));
            chk("overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    // Called at a negedge: present a request for one edge, then scramble the inputs.
    task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        start = 1'b1;
        a = ta;
        b = tb;
        cin = tc;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
    endtask

    task automatic expect_done(input string nm, input logic [W-1:0] es, input logic ec,
                               input logic eo);
        int k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_done_seen"}, 32'(done), 32'd1);
        chk({nm, "_sum"}, 32'(sum), 32'(es));
        chk({nm, "_cout"}, 32'(cout), 32'(ec));
        chk({nm, "_ovf"}, 32'(overflow), 32'(eo));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b0, {(W-1){1'b1}}};
            3:       return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int nb, np, t0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add and busy window length
        drive(16'h1234, 16'h4321, 1'b0);
        nb = 0;
        while (busy && nb < 20) begin
            nb++;
            @(negedge clk);
        end
        chk("t1_busy_cycles", 32'(nb), 32'd4);
        expect_done("t1", 16'h5555, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_done_width", 32'(done), 32'd0);

        drive(16'hFFFF, 16'h0000, 1'b1);
        expect_done("ripple", 16'h0000, 1'b1, 1'b0);
        drive(16'h7FFF, 16'h0001, 1'b0);
        expect_done("posovf", 16'h8000, 1'b0, 1'b1);
        drive(16'h8000, 16'h8000, 1'b0);
        expect_done("negovf", 16'h0000, 1'b1, 1'b1);
        @(negedge clk);

        // A second start during RUN is dropped
        drive(16'h000A, 16'h0002, 1'b0);
        start = 1'b1;
        a = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        expect_done("ignore", 16'h000C, 1'b0, 1'b0);
        np = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) np++;
        end
        chk("ignore_extra_done", 32'(np), 32'd0);

        // Back-to-back: new request held during the DONE cycle
        drive(16'h0010, 16'h0020, 1'b0);
        expect_done("b2b_first", 16'h0030, 1'b0, 1'b0);
        t0 = cyc;
        drive(16'h00FF, 16'h0001, 1'b0);
        chk("b2b_no_bubble", 32'(busy), 32'd1);
        expect_done("b2b_second", 16'h0100, 1'b0, 1'b0);
        chk("b2b_spacing", 32'(cyc - t0), 32'd5);

        // Asynchronous reset during the second RUN cycle
        @(negedge clk);
        drive(16'h1111, 16'h1111, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_sum", 32'(sum), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        np = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) np++;
        end
        chk("arst_no_done", 32'(np), 32'd0);
        drive(16'h0001, 16'h0001, 1'b0);
        expect_done("after_rst", 16'h0002, 1'b0, 1'b0);

        // Random traffic: idle gaps, back-to-back requests and stray starts during RUN
        repeat (900) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            a = pick();
            b = pick();
            cin = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
